// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU op codes, control bundle, bubble.
package id_ex_operand_stage_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SLTU = 4'd14;
  localparam logic [3:0] ALU_SRA  = 4'd15;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic [3:0] aluctl;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Per-operand bypass: MEM result beats WB data beats the captured register value.
module id_ex_operand_stage_fwd_select
  import id_ex_operand_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] src_reg_i,
  input  logic [WIDTH-1:0] cap_data_i,
  input  logic             mem_regwrite_i,
  input  logic             mem_memread_i,
  input  logic [RADDR-1:0] mem_writereg_i,
  input  logic [WIDTH-1:0] mem_result_i,
  input  logic             wb_regwrite_i,
  input  logic [RADDR-1:0] wb_writereg_i,
  input  logic [WIDTH-1:0] wb_data_i,
  output logic [WIDTH-1:0] data_o
);

  logic mem_hit, wb_hit;

  // A load in MEM has no data yet; that case is covered by the load-use stall.
  assign mem_hit = mem_regwrite_i & ~mem_memread_i &
                   (mem_writereg_i != RADDR'(REG_ZERO)) & (mem_writereg_i == src_reg_i);
  assign wb_hit  = wb_regwrite_i &
                   (wb_writereg_i != RADDR'(REG_ZERO)) & (wb_writereg_i == src_reg_i);

  always_comb begin
    data_o = cap_data_i;
    if (mem_hit)     data_o = mem_result_i;
    else if (wb_hit) data_o = wb_data_i;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use stall/bubble, WB write-through and EX operand forwarding.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ID_Valid,
  input  logic [WIDTH-1:0] ID_ReadData1,
  input  logic [WIDTH-1:0] ID_ReadData2,
  input  logic [WIDTH-1:0] ID_Imm,
  input  logic [RADDR-1:0] ID_Rs,
  input  logic [RADDR-1:0] ID_Rt,
  input  logic [RADDR-1:0] ID_WriteReg,
  input  logic [3:0]       ID_ALUControl,
  input  logic             ID_ALUSrc,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_MemWrite,
  input  logic             ID_MemToReg,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic [RADDR-1:0] MEM_WriteReg,
  input  logic [WIDTH-1:0] MEM_ALUResult,
  input  logic             WB_RegWrite,
  input  logic [RADDR-1:0] WB_WriteReg,
  input  logic [WIDTH-1:0] WB_WriteData,
  input  logic             Flush,
  output logic             StallID,
  output logic [3:0]       EX_ALUControl,
  output logic [WIDTH-1:0] EX_A,
  output logic [WIDTH-1:0] EX_B,
  output logic [WIDTH-1:0] EX_StoreData,
  output logic [RADDR-1:0] EX_WriteReg,
  output logic             EX_Valid,
  output logic             EX_RegWrite,
  output logic             EX_MemRead,
  output logic             EX_MemWrite,
  output logic             EX_MemToReg
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [RADDR-1:0] rs_q, rt_q, wreg_q;
  logic [WIDTH-1:0] rd1_q, rd2_q, imm_q, rd1_d, rd2_d;
  logic [WIDTH-1:0] fwd_rs, fwd_rt;
  logic             hz, wb_live;

  assign hz = ctrl_q.valid & ctrl_q.memread & (wreg_q != RADDR'(REG_ZERO)) & ID_Valid &
              ((ID_Rs == wreg_q) | (ID_Rt == wreg_q));
  assign StallID = hz & ~Flush;

  // Register file is written at the same edge we read it, so pick up the WB value now.
  assign wb_live = WB_RegWrite & (WB_WriteReg != RADDR'(REG_ZERO));
  assign rd1_d   = (wb_live && WB_WriteReg == ID_Rs) ? WB_WriteData : ID_ReadData1;
  assign rd2_d   = (wb_live && WB_WriteReg == ID_Rt) ? WB_WriteData : ID_ReadData2;

  always_comb begin
    ctrl_d          = CTRL_BUBBLE;
    ctrl_d.valid    = ID_Valid;
    ctrl_d.regwrite = ID_RegWrite;
    ctrl_d.memread  = ID_MemRead;
    ctrl_d.memwrite = ID_MemWrite;
    ctrl_d.memtoreg = ID_MemToReg;
    ctrl_d.alusrc   = ID_ALUSrc;
    ctrl_d.aluctl   = ID_ALUControl;
  end

  always_ff @(posedge Clk) begin
    if (Rst || Flush || hz) begin
      ctrl_q <= CTRL_BUBBLE;
      rs_q   <= '0;
      rt_q   <= '0;
      wreg_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rs_q   <= ID_Rs;
      rt_q   <= ID_Rt;
      wreg_q <= ID_WriteReg;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= ID_Imm;
    end
  end

  id_ex_operand_stage_fwd_select #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs (
    .src_reg_i(rs_q), .cap_data_i(rd1_q),
    .mem_regwrite_i(MEM_RegWrite), .mem_memread_i(MEM_MemRead),
    .mem_writereg_i(MEM_WriteReg), .mem_result_i(MEM_ALUResult),
    .wb_regwrite_i(WB_RegWrite), .wb_writereg_i(WB_WriteReg), .wb_data_i(WB_WriteData),
    .data_o(fwd_rs)
  );

  id_ex_operand_stage_fwd_select #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rt (
    .src_reg_i(rt_q), .cap_data_i(rd2_q),
    .mem_regwrite_i(MEM_RegWrite), .mem_memread_i(MEM_MemRead),
    .mem_writereg_i(MEM_WriteReg), .mem_result_i(MEM_ALUResult),
    .wb_regwrite_i(WB_RegWrite), .wb_writereg_i(WB_WriteReg), .wb_data_i(WB_WriteData),
    .data_o(fwd_rt)
  );

  assign EX_A          = fwd_rs;
  assign EX_StoreData  = fwd_rt;
  assign EX_B          = ctrl_q.alusrc ? imm_q : fwd_rt;
  assign EX_ALUControl = ctrl_q.aluctl;
  assign EX_WriteReg   = wreg_q;
  assign EX_Valid      = ctrl_q.valid;
  assign EX_RegWrite   = ctrl_q.regwrite;
  assign EX_MemRead    = ctrl_q.memread;
  assign EX_MemWrite   = ctrl_q.memwrite;
  assign EX_MemToReg   = ctrl_q.memtoreg;

endmodule
